// File: rtl/rst_decipher_if.sv
// ----------------------------------------------------------------------------
// rst_decipher_if
// Groups the key-install, ciphertext-in and plaintext/error-out signals of the
// rst_decipher receive block.
//   master : drives key, key_install, ctxt_valid, ctxt_str; observes results
//   slave  : the decipher block itself
// Signals:
//   key [11:0][7:0]        12-character key, key[11] is the first character
//   key_install            one-cycle strobe that samples and checks key
//   ctxt_valid / ctxt_str  ciphertext pair {row char, column char}
//   ptxt_char / ptxt_ready decrypted character and its one-cycle valid pulse
//   err_*                  one-cycle error pulses
// ----------------------------------------------------------------------------
interface rst_decipher_if;
    logic [11:0][7:0] key;
    logic             key_install;
    logic             ctxt_valid;
    logic [15:0]      ctxt_str;
    logic [7:0]       ptxt_char;
    logic             ptxt_ready;
    logic             err_invalid_key;
    logic             err_key_not_installed;
    logic             err_invalid_ctxt;

    modport master (
        output key, key_install, ctxt_valid, ctxt_str,
        input  ptxt_char, ptxt_ready, err_invalid_key,
               err_key_not_installed, err_invalid_ctxt
    );

    modport slave (
        input  key, key_install, ctxt_valid, ctxt_str,
        output ptxt_char, ptxt_ready, err_invalid_key,
               err_key_not_installed, err_invalid_ctxt
    );
endinterface

// File: rtl/rst_decipher.sv
// ----------------------------------------------------------------------------
// rst_decipher
// Receive-side decoder for the rotating 6x6 substitution cipher. A key install
// loads six row characters and six column characters; each valid ciphertext
// pair {row char, column char} selects cell 6*row + col, which maps to
// 'a'..'z' (cells 0..25) or '0'..'9' (cells 26..35). Every successful decode
// rotates both the row and the column sets by one position.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rst_decipher_if.slave (key install, ciphertext in, plaintext/errors out)
// All outputs are registered: one cycle of latency, one pair per cycle.
// ----------------------------------------------------------------------------
module rst_decipher (
    input  logic           clk,
    input  logic           rst,
    rst_decipher_if.slave  bus
);

    typedef enum logic { NO_KEY, KEYED } state_t;

    state_t          state, state_d;
    logic [5:0][7:0] rows, cols;   // rows[k] = Rk, cols[k] = Ck

    logic            key_ok;
    logic            row_hit, col_hit;
    logic [2:0]      row_idx, col_idx;
    logic [5:0]      cell_idx;
    logic [7:0]      cell_char;

    logic            load_table, rotate_table;
    logic [7:0]      char_d;
    logic            ready_d, e_key_d, e_nokey_d, e_ctxt_d;

    logic [7:0]      char_q;
    logic            ready_q, e_key_q, e_nokey_q, e_ctxt_q;

    // Key must be twelve distinct lowercase letters.
    always_comb begin
        key_ok = 1'b1;
        for (int a = 0; a < 12; a++) begin
            if (bus.key[a] < 8'h61 || bus.key[a] > 8'h7a) key_ok = 1'b0;
            for (int b = a + 1; b < 12; b++) begin
                if (bus.key[a] == bus.key[b]) key_ok = 1'b0;
            end
        end
    end

    // Table lookup. A valid key makes all twelve characters distinct, so at
    // most one row and one column can match.
    always_comb begin
        row_hit = 1'b0;
        row_idx = 3'd0;
        col_hit = 1'b0;
        col_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (rows[i] == bus.ctxt_str[15:8]) begin
                row_hit = 1'b1;
                row_idx = 3'(i);
            end
            if (cols[i] == bus.ctxt_str[7:0]) begin
                col_hit = 1'b1;
                col_idx = 3'(i);
            end
        end
    end

    assign cell_idx  = 6'(row_idx) * 6'd6 + 6'(col_idx);
    assign cell_char = (cell_idx < 6'd26) ? 8'h61 + 8'(cell_idx)
                                          : 8'h30 + 8'(cell_idx) - 8'd26;

    // Next-state and next-output logic. Install outranks a same-cycle pair.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state;
        load_table   = 1'b0;
        rotate_table = 1'b0;
        char_d       = char_q;
        ready_d      = 1'b0;
        e_key_d      = 1'b0;
        e_nokey_d    = 1'b0;
        e_ctxt_d     = 1'b0;

        if (bus.key_install) begin
            if (key_ok) begin
                state_d    = KEYED;
                load_table = 1'b1;
            end else begin
                state_d = NO_KEY;
                e_key_d = 1'b1;
            end
        end else if (bus.ctxt_valid) begin
            if (state == NO_KEY) begin
                e_nokey_d = 1'b1;
                char_d    = 8'h00;
            end else if (row_hit && col_hit) begin
                char_d       = cell_char;
                ready_d      = 1'b1;
                rotate_table = 1'b1;
            end else begin
                e_ctxt_d = 1'b1;
                char_d   = 8'h00;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NO_KEY;
            char_q    <= 8'h00;
            ready_q   <= 1'b0;
            e_key_q   <= 1'b0;
            e_nokey_q <= 1'b0;
            e_ctxt_q  <= 1'b0;
        end else begin
            state     <= state_d;
            char_q    <= char_d;
            ready_q   <= ready_d;
            e_key_q   <= e_key_d;
            e_nokey_q <= e_nokey_d;
            e_ctxt_q  <= e_ctxt_d;
        end
    end

    // NOTE: the table is reset explicitly: only twelve bytes of flops, and a
    // cleared table guarantees no stale key survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows <= '0;
            cols <= '0;
        end else if (load_table) begin
            rows <= {bus.key[5], bus.key[7], bus.key[3],
                     bus.key[9], bus.key[1], bus.key[11]};
            cols <= {bus.key[4], bus.key[6], bus.key[2],
                     bus.key[8], bus.key[0], bus.key[10]};
        end else if (rotate_table) begin
            // R0 <= R5, Rk <= Rk-1 (same for columns)
            rows <= {rows[4:0], rows[5]};
            cols <= {cols[4:0], cols[5]};
        end
    end

    assign bus.ptxt_char             = char_q;
    assign bus.ptxt_ready            = ready_q;
    assign bus.err_invalid_key       = e_key_q;
    assign bus.err_key_not_installed = e_nokey_q;
    assign bus.err_invalid_ctxt      = e_ctxt_q;

endmodule

// File: tb/tb_rst_decipher.sv
// ----------------------------------------------------------------------------
// tb_rst_decipher
// Self-checking bench for rst_decipher. A reference model keeps the initial
// row/column sets plus a rotation count and decodes pairs arithmetically.
// ----------------------------------------------------------------------------
module tb_rst_decipher;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rst_decipher_if bus ();

    rst_decipher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observed bundle: {ready, err_key_not_installed, err_invalid_key,
    // err_invalid_ctxt, ptxt_char}
    logic [11:0] obs;
    assign obs = {bus.ptxt_ready, bus.err_key_not_installed, bus.err_invalid_key,
                  bus.err_invalid_ctxt, bus.ptxt_char};

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_b;

    localparam logic [11:0][7:0] KEY_A = "abcdefghijkl";
    localparam logic [35:0][7:0] ALPHABET = "abcdefghijklmnopqrstuvwxyz0123456789";

    // ---------------- reference model ----------------
    const int row_sel [6] = '{11, 1, 9, 3, 7, 5};
    const int col_sel [6] = '{10, 0, 8, 2, 6, 4};

    logic       m_keyed;
    logic [7:0] m_rows [6];
    logic [7:0] m_cols [6];
    int         m_rot;
    logic [7:0] m_char;

    function automatic logic key_valid(input logic [11:0][7:0] k);
        for (int a = 0; a < 12; a++) begin
            if (k[a] < "a" || k[a] > "z") return 1'b0;
            for (int b = 0; b < 12; b++)
                if (a != b && k[a] == k[b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Character currently at row / column position p after m_rot rotations.
    function automatic logic [7:0] row_at(input int p);
        return m_rows[(p - m_rot + 6) % 6];
    endfunction
    function automatic logic [7:0] col_at(input int p);
        return m_cols[(p - m_rot + 6) % 6];
    endfunction

    function automatic logic [15:0] pair_for(input int idx);
        return {row_at(idx / 6), col_at(idx % 6)};
    endfunction

    task automatic model_reset();
        m_keyed = 1'b0;
        m_rot   = 0;
        m_char  = 8'h00;
        for (int p = 0; p < 6; p++) begin
            m_rows[p] = 8'h00;
            m_cols[p] = 8'h00;
        end
    endtask

    task automatic model_step(input logic inst, input logic [11:0][7:0] k,
                              input logic v, input logic [15:0] s,
                              output logic [11:0] e);
        logic rdy = 1'b0, eknk = 1'b0, eik = 1'b0, eic = 1'b0;
        int ri = -1, ci = -1;
        if (inst) begin
            if (key_valid(k)) begin
                m_keyed = 1'b1;
                m_rot   = 0;
                for (int p = 0; p < 6; p++) begin
                    m_rows[p] = k[row_sel[p]];
                    m_cols[p] = k[col_sel[p]];
                end
            end else begin
                m_keyed = 1'b0;
                eik     = 1'b1;
            end
        end else if (v) begin
            if (!m_keyed) begin
                eknk   = 1'b1;
                m_char = 8'h00;
            end else begin
                for (int p = 0; p < 6; p++) begin
                    if (row_at(p) == s[15:8]) ri = p;
                    if (col_at(p) == s[7:0])  ci = p;
                end
                if (ri >= 0 && ci >= 0) begin
                    int idx = 6 * ri + ci;
                    m_char = (idx < 26) ? 8'("a" + idx) : 8'("0" + idx - 26);
                    rdy    = 1'b1;
                    m_rot  = (m_rot + 1) % 6;
                end else begin
                    eic    = 1'b1;
                    m_char = 8'h00;
                end
            end
        end
        e = {rdy, eknk, eik, eic, m_char};
    endtask

    // ---------------- stimulus ----------------
    task automatic apply(input logic inst, input logic [11:0][7:0] k,
                         input logic v, input logic [15:0] s);
        @(negedge clk);
        bus.key_install = inst;
        bus.key         = k;
        bus.ctxt_valid  = v;
        bus.ctxt_str    = s;
        @(posedge clk);
        model_step(inst, k, v, s, exp_b);
        #1;
        bus.key_install = 1'b0;
        bus.ctxt_valid  = 1'b0;
    endtask

    function automatic logic [11:0][7:0] random_key(input logic make_valid);
        logic [7:0] pool [26];
        logic [11:0][7:0] k;
        for (int i = 0; i < 26; i++) pool[i] = 8'("a" + i);
        for (int i = 25; i > 0; i--) begin
            int j = $urandom_range(i, 0);
            logic [7:0] t = pool[i];
            pool[i] = pool[j];
            pool[j] = t;
        end
        for (int i = 0; i < 12; i++) k[i] = pool[i];
        if (!make_valid) begin
            if ($urandom_range(1, 0) == 0) k[$urandom_range(11, 0)] = 8'($urandom_range(8'h40, 8'h20));
            else k[$urandom_range(5, 0)] = k[$urandom_range(11, 6)];
        end
        return k;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.key_install = 1'b0;
        bus.ctxt_valid  = 1'b0;
        bus.key         = '0;
        bus.ctxt_str    = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", obs, 12'h000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_decode();
        logic [15:0] seq [3] = '{"ab", "gh", "ab"};
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        vectors++;
        if (obs !== exp_b) begin miscompares++; $display("FAIL basic_install: got %h want %h", obs, exp_b); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, KEY_A, 1'b1, seq[i]);
            vectors++;
            if (obs !== exp_b) begin miscompares++; $display("FAIL basic_decode[%0d]: got %h want %h", i, obs, exp_b); end
        end
    endtask

    task automatic test_corner();
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        apply(1'b0, KEY_A, 1'b1, "ed");
        vectors++;
        if (obs !== {4'b1000, 8'h30}) begin miscompares++; $display("FAIL corner_idx26: got %h want %h", obs, {4'b1000, 8'h30}); end
        apply(1'b0, KEY_A, 1'b1, "ei");
        vectors++;
        if (obs !== exp_b) begin miscompares++; $display("FAIL corner_bad_col: got %h want %h", obs, exp_b); end
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        apply(1'b0, KEY_A, 1'b1, "gh");
        vectors++;
        if (obs !== {4'b1000, 8'h39}) begin miscompares++; $display("FAIL corner_idx35: got %h want %h", obs, {4'b1000, 8'h39}); end
    endtask

    task automatic test_bad_ctxt();
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        apply(1'b0, KEY_A, 1'b1, "bb");
        vectors++;
        if (obs !== {4'b0001, 8'h00}) begin miscompares++; $display("FAIL bad_ctxt: got %h want %h", obs, {4'b0001, 8'h00}); end
        apply(1'b0, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== {4'b1000, 8'h61}) begin miscompares++; $display("FAIL bad_ctxt_no_rotate: got %h want %h", obs, {4'b1000, 8'h61}); end
    endtask

    task automatic test_bad_key();
        logic [11:0][7:0] bad [2] = '{"abcdabcdabcd", "abcde???ijkl"};
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, bad[i], 1'b0, 16'h0);
            vectors++;
            if (obs !== exp_b || !bus.err_invalid_key) begin miscompares++; $display("FAIL bad_key[%0d]: got %h want %h", i, obs, exp_b); end
            apply(1'b0, KEY_A, 1'b1, "ab");
            vectors++;
            if (obs !== {4'b0100, 8'h00}) begin miscompares++; $display("FAIL bad_key_nokey[%0d]: got %h want %h", i, obs, {4'b0100, 8'h00}); end
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        apply(1'b0, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== exp_b) begin miscompares++; $display("FAIL pre_reset: got %h want %h", obs, exp_b); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs !== 12'h000) begin miscompares++; $display("FAIL async_reset: got %h want %h", obs, 12'h000); end
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== {4'b0100, 8'h00}) begin miscompares++; $display("FAIL post_reset_nokey: got %h want %h", obs, {4'b0100, 8'h00}); end
        apply(1'b1, KEY_A, 1'b0, 16'h0);
        apply(1'b0, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== {4'b1000, 8'h61}) begin miscompares++; $display("FAIL post_reset_decode: got %h want %h", obs, {4'b1000, 8'h61}); end
    endtask

    task automatic test_install_priority();
        apply(1'b1, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== exp_b || bus.ptxt_ready) begin miscompares++; $display("FAIL install_priority: got %h want %h", obs, exp_b); end
        apply(1'b0, KEY_A, 1'b1, "ab");
        vectors++;
        if (obs !== {4'b1000, 8'h61}) begin miscompares++; $display("FAIL install_priority_next: got %h want %h", obs, {4'b1000, 8'h61}); end
    endtask

    // Encrypt every cell back-to-back with a fresh random key and expect the
    // plaintext alphabet in order.
    task automatic test_full_stream();
        logic [11:0][7:0] k = random_key(1'b1);
        apply(1'b1, k, 1'b0, 16'h0);
        for (int idx = 0; idx < 36; idx++) begin
            apply(1'b0, k, 1'b1, pair_for(idx));
            vectors++;
            if (obs !== {4'b1000, ALPHABET[35 - idx]}) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h want %h", idx, obs, {4'b1000, ALPHABET[35 - idx]});
            end
        end
    endtask

    task automatic test_random();
        logic [11:0][7:0] k = random_key(1'b1);
        apply(1'b1, k, 1'b0, 16'h0);
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(99, 0);
            logic [15:0] s;
            if ($urandom_range(4, 0) != 0) s = pair_for($urandom_range(35, 0));
            else s = {8'($urandom_range(8'h7a, 8'h61)), 8'($urandom_range(8'h7a, 8'h61))};
            if (r < 5)       apply(1'b1, random_key($urandom_range(1, 0) == 1), $urandom_range(1, 0) == 1, s);
            else if (r < 85) apply(1'b0, k, 1'b1, s);
            else             apply(1'b0, k, 1'b0, s);
            vectors++;
            if (obs !== exp_b) begin miscompares++; $display("FAIL random[%0d]: got %h want %h", n, obs, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_corner();
        test_bad_ctxt();
        test_bad_key();
        test_async_reset();
        test_install_priority();
        test_full_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
